mcast_bus_tx: RTL and testbench



---
 rtl/mcast_bus_tx.sv | 160 ++++++++++++++++
 tb/tb_mcast_bus_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcast_bus_tx.sv
// rtl/mcast_bus_tx.sv - global-bus broadcast transmitter with round-robin psum return
// Optional ready-wait timeout detection is built when MCAST_TX_TIMEOUT_EN is defined.
module mcast_bus_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_MC     = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_type,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  input  logic [2*DATA_WIDTH-1:0]      in_data,
  output logic [TAG_WIDTH-1:0]         TAG,
  output logic [2:0]                   CASTER_EN,
  output logic [DATA_WIDTH-1:0]        ifmap_data_B2M,
  output logic [DATA_WIDTH-1:0]        fltr_data_B2M,
  output logic [2*DATA_WIDTH-1:0]      psum_data_B2M,
  input  logic [NUM_MC-1:0]            CASTER_READY,
  input  logic [NUM_MC-1:0]            CASTER_VALID,
  input  logic [NUM_MC*2*DATA_WIDTH-1:0] psum_data_M2B,
  output logic [NUM_MC-1:0]            PSUM_ACK,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*DATA_WIDTH-1:0]      out_data,
  output logic [((NUM_MC > 1) ? $clog2(NUM_MC) : 1)-1:0] out_mc_idx,
  output logic [7:0]                   drop_cnt,
  output logic                         err_timeout
);

  localparam int IDXW = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
  localparam int PW   = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // NUM_COL only describes the bus geometry seen by the casters.
  if (NUM_COL < 1) begin : g_no_columns
  end

  logic [1:0] state;
  logic       all_ready;

  assign all_ready = &CASTER_READY;
  assign in_ready  = rstn && (state == ST_IDLE) && in_valid &&
                     ((in_type == 2'd3) || all_ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      TAG            <= '0;
      CASTER_EN      <= '0;
      ifmap_data_B2M <= '0;
      fltr_data_B2M  <= '0;
      psum_data_B2M  <= '0;
      drop_cnt       <= '0;
    end else begin
      CASTER_EN <= '0;
      case (state)
        ST_IDLE: begin
          if (in_ready) begin
            if (in_type == 2'd3) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else begin
              TAG       <= in_tag;
              CASTER_EN <= 3'b001 << in_type;
              state     <= ST_ISSUE;
              case (in_type)
                2'd0:    ifmap_data_B2M <= in_data[DATA_WIDTH-1:0];
                2'd1:    fltr_data_B2M  <= in_data[DATA_WIDTH-1:0];
                default: psum_data_B2M  <= in_data;
              endcase
            end
          end
        end
        ST_ISSUE: state <= ST_GAP;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A caster still shows VALID during its ack cycle, so it is masked then.
  logic [NUM_MC-1:0]   elig;
  logic [2*NUM_MC-1:0] rot_dbl;
  logic                grant_any;
  logic [IDXW-1:0]     grant;
  logic [IDXW-1:0]     next_ptr;
  logic [IDXW-1:0]     rr_ptr;
  logic [PW-1:0]       grant_data;
  int                  off;
  int                  gsum;

  assign elig = CASTER_VALID & ~PSUM_ACK;

  always_comb begin
    rot_dbl    = {elig, elig} >> rr_ptr;
    grant_any  = 1'b0;
    off        = 0;
    for (int k = NUM_MC - 1; k >= 0; k--) begin
      if (rot_dbl[k]) begin
        grant_any = 1'b1;
        off       = k;
      end
    end
    gsum = int'(rr_ptr) + off;
    if (gsum >= NUM_MC) gsum = gsum - NUM_MC;
    grant    = IDXW'(gsum);
    next_ptr = (gsum + 1 >= NUM_MC) ? '0 : IDXW'(gsum + 1);
    grant_data = '0;
    for (int k = 0; k < NUM_MC; k++) begin
      if (grant == IDXW'(k)) grant_data = psum_data_M2B[k*PW +: PW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mc_idx <= '0;
      PSUM_ACK   <= '0;
      rr_ptr     <= '0;
    end else begin
      PSUM_ACK <= '0;
      if (!out_valid || out_ready) begin
        if (grant_any) begin
          out_valid       <= 1'b1;
          out_data        <= grant_data;
          out_mc_idx      <= grant;
          PSUM_ACK[grant] <= 1'b1;
          rr_ptr          <= next_ptr;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef MCAST_TX_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if ((state == ST_IDLE) && in_valid && (in_type != 2'd3) && !all_ready) begin
      if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
      if ({16'd0, wait_cnt} + 32'd1 >= 32'(TIMEOUT)) err_timeout <= 1'b1;
    end else if (in_ready || !in_valid) begin
      wait_cnt <= '0;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mcast_bus_tx.sv
// tb/tb_mcast_bus_tx.sv - randomized bench for mcast_bus_tx against a behavioural model
module tb_mcast_bus_tx;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_type;
  logic [3:0]   in_tag;
  logic [31:0]  in_data;
  logic [3:0]   TAG;
  logic [2:0]   CASTER_EN;
  logic [15:0]  ifmap_data_B2M;
  logic [15:0]  fltr_data_B2M;
  logic [31:0]  psum_data_B2M;
  logic [3:0]   CASTER_READY;
  logic [3:0]   CASTER_VALID;
  logic [127:0] psum_data_M2B;
  logic [3:0]   PSUM_ACK;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_mc_idx;
  logic [7:0]   drop_cnt;
  logic         err_timeout;

  mcast_bus_tx #(.DATA_WIDTH(16), .NUM_COL(4), .NUM_MC(4), .TAG_WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_tag(in_tag), .in_data(in_data),
    .TAG(TAG), .CASTER_EN(CASTER_EN), .ifmap_data_B2M(ifmap_data_B2M),
    .fltr_data_B2M(fltr_data_B2M), .psum_data_B2M(psum_data_B2M),
    .CASTER_READY(CASTER_READY), .CASTER_VALID(CASTER_VALID), .psum_data_M2B(psum_data_M2B),
    .PSUM_ACK(PSUM_ACK), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mc_idx(out_mc_idx), .drop_cnt(drop_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  int          m_busy;       // cycles left before the bus is free again
  logic [3:0]  m_tag;
  logic [2:0]  m_en;
  logic [15:0] m_if, m_fl;
  logic [31:0] m_ps;
  int          m_drop;
  logic        m_ov;
  logic [31:0] m_od;
  int          m_idx;
  logic [3:0]  m_ack;
  int          m_ptr;
  int          m_wait;
  logic        m_err;
  logic        exp_rdy;

  // caster environment
  logic [3:0]  pend;
  logic [31:0] cdata [4];
  logic [3:0]  ack_hist;
  bit          env_on;

  task automatic model_reset();
    m_busy = 0; m_tag = '0; m_en = '0; m_if = '0; m_fl = '0; m_ps = '0; m_drop = 0;
    m_ov = 1'b0; m_od = '0; m_idx = 0; m_ack = '0; m_ptr = 0; m_wait = 0; m_err = 1'b0;
  endtask

  task automatic cycle(input bit do_reset);
    logic [3:0] elig;
    logic [3:0] new_ack;
    int         busy0;
    bit         found;
    int         g;
    @(negedge clk);
    rstn = !do_reset;
    pend = pend & ~ack_hist;
    ack_hist = m_ack;
    for (int i = 0; i < 4; i++) begin
      if (env_on && !pend[i] && $urandom_range(0, 2) == 0) begin
        pend[i] = 1'b1;
        cdata[i] = $urandom;
      end
    end
    CASTER_VALID = pend;
    for (int i = 0; i < 4; i++) psum_data_M2B[i*32 +: 32] = cdata[i];
    #1;
    exp_rdy = rstn && (m_busy == 0) && in_valid && ((in_type == 2'd3) || (CASTER_READY == 4'hF));
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      busy0 = m_busy;
      m_en = '0;
      if (m_busy > 0) m_busy--;
      if (exp_rdy) begin
        if (in_type == 2'd3) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_tag = in_tag;
          m_en = 3'(1 << in_type);
          m_busy = 2;
          if (in_type == 2'd0) m_if = in_data[15:0];
          else if (in_type == 2'd1) m_fl = in_data[15:0];
          else m_ps = in_data;
        end
      end
`ifdef MCAST_TX_TIMEOUT_EN
      if (busy0 == 0 && in_valid && in_type != 2'd3 && CASTER_READY != 4'hF) begin
        m_wait++;
        if (m_wait >= 8) m_err = 1'b1;
      end else if (exp_rdy || !in_valid) begin
        m_wait = 0;
      end
`endif
      elig = CASTER_VALID & ~m_ack;
      new_ack = '0;
      if (!m_ov || out_ready) begin
        found = 0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && elig[(m_ptr + k) % 4]) begin
            found = 1;
            g = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          m_ov = 1'b1;
          m_od = cdata[g];
          m_idx = g;
          new_ack[g] = 1'b1;
          m_ptr = (g + 1) % 4;
        end else begin
          m_ov = 1'b0;
        end
      end
      m_ack = new_ack;
    end
    #1;
    check("caster_en", CASTER_EN, m_en);
    check("tag", TAG, m_tag);
    check("ifmap", ifmap_data_B2M, m_if);
    check("fltr", fltr_data_B2M, m_fl);
    check("psum_b2m", psum_data_B2M, m_ps);
    check("drop_cnt", drop_cnt, m_drop);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_mc_idx", out_mc_idx, m_idx);
    check("psum_ack", PSUM_ACK, m_ack);
    check("err_timeout", err_timeout, m_err);
  endtask

  task automatic send(input logic [1:0] t, input logic [3:0] tg, input logic [31:0] d);
    int guard;
    in_valid = 1'b1; in_type = t; in_tag = tg; in_data = d;
    guard = 0;
    do begin
      cycle(0);
      guard++;
    end while (!exp_rdy && guard < 50);
    if (guard >= 50) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_type = '0; in_tag = '0; in_data = '0;
    CASTER_READY = 4'hF; CASTER_VALID = '0; psum_data_M2B = '0; out_ready = 1'b1;
    pend = '0; ack_hist = '0; env_on = 0;
    for (int i = 0; i < 4; i++) cdata[i] = '0;
    model_reset();
    cycle(1);
    cycle(1);
    check("rst_en", CASTER_EN, 3'd0);
    check("rst_outv", out_valid, 1'b0);

    // single ifmap broadcast
    send(2'd0, 4'd5, 32'h1234);
    check("ifmap_en", CASTER_EN, 3'b001);
    check("ifmap_tag", TAG, 4'd5);
    check("ifmap_data", ifmap_data_B2M, 16'h1234);
    cycle(0);
    check("ifmap_en_off", CASTER_EN, 3'd0);
    cycle(0);

    // ready stall: five blocked cycles then accept
    CASTER_READY = 4'b1011;
    in_valid = 1'b1; in_type = 2'd1; in_tag = 4'd3; in_data = 32'h0000_BEEF;
    for (int i = 0; i < 5; i++) cycle(0);
    CASTER_READY = 4'hF;
    send(2'd1, 4'd3, 32'h0000_BEEF);
    check("fltr_en", CASTER_EN, 3'b010);
    check("fltr_data", fltr_data_B2M, 16'hBEEF);
    cycle(0); cycle(0);

    // back-to-back psum packets at peak rate
    send(2'd2, 4'd1, 32'hA);
    check("psum_a", psum_data_B2M, 32'hA);
    send(2'd2, 4'd1, 32'hB);
    check("psum_b", psum_data_B2M, 32'hB);
    send(2'd2, 4'd1, 32'hC);
    check("psum_c", psum_data_B2M, 32'hC);
    cycle(0); cycle(0);

    // reserved packets, then saturation of the drop counter
    send(2'd3, 4'd0, 32'd0);
    send(2'd3, 4'd0, 32'd0);
    check("drop_two", drop_cnt, 8'd2);
    for (int i = 0; i < 256; i++) send(2'd3, 4'(i), 32'(i));
    check("drop_sat", drop_cnt, 8'd255);

    // ready-wait timeout scenario
    CASTER_READY = 4'h0;
    in_valid = 1'b1; in_type = 2'd0; in_tag = 4'd9; in_data = 32'h55;
    for (int i = 0; i < 9; i++) cycle(0);
`ifdef MCAST_TX_TIMEOUT_EN
    check("timeout_set", err_timeout, 1'b1);
`else
    check("timeout_off", err_timeout, 1'b0);
`endif
    CASTER_READY = 4'hF;
    send(2'd0, 4'd9, 32'h55);
    cycle(0); cycle(0);
`ifdef MCAST_TX_TIMEOUT_EN
    check("timeout_sticky", err_timeout, 1'b1);
`endif

    // reset while a strobe is pending
    in_valid = 1'b1; in_type = 2'd2; in_tag = 4'd7; in_data = 32'hDEAD;
    cycle(0);
    in_valid = 1'b0;
    cycle(1);
    check("midrst_en", CASTER_EN, 3'd0);
    cycle(0);

    // randomized traffic on both paths
    env_on = 1;
    for (int n = 0; n < 4000; n++) begin
      if (!in_valid || exp_rdy || $urandom_range(0, 15) == 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_type = 2'($urandom_range(0, 3));
        in_tag = 4'($urandom);
        in_data = $urandom;
      end
      CASTER_READY = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (n == 1500) out_ready = 1'b0;
      cycle($urandom_range(0, 599) == 0);
    end

    // return stream must hold while downstream stalls
    out_ready = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0);
    check("stall_noack", PSUM_ACK, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
